// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS datapath constants, multiply FSM states and counter width.
package mips_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3} mult_state_t;
  localparam logic [3:0] ALU_MULT  = 4'b1000;
  localparam logic [3:0] ALU_MULTU = 4'b1001;
  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);
endpackage

// File: rtl/mult_sequencer_if.sv
// mult_sequencer_if: control-unit <-> multiply sequencer handshake and HI/LO readback.
interface mult_sequencer_if #(parameter int WIDTH = 32);
  logic             start, signed_op, abort, busy, done;
  logic [WIDTH-1:0] a, b, hi, lo;
  modport master (output start, signed_op, a, b, abort, input busy, done, hi, lo);
  modport slave  (input start, signed_op, a, b, abort, output busy, done, hi, lo);
endinterface

// File: rtl/mult_datapath.sv
// mult_datapath: radix-2 shift-add product register with sign handling.
module mult_datapath #(parameter int WIDTH = 32) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               fix,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result
);
  logic [WIDTH-1:0]   mcand, a_mag, b_mag;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     sum;
  logic               neg;
  // prod holds {accumulator, remaining multiplier bits}; after WIDTH steps it is the unsigned product
  always_comb begin
    a_mag  = (signed_op && a[WIDTH-1]) ? -a : a;
    b_mag  = (signed_op && b[WIDTH-1]) ? -b : b;
    sum    = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    result = neg ? -prod : prod;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mcand <= '0;
      prod  <= '0;
      neg   <= 1'b0;
    end else if (load) begin
      mcand <= a_mag;
      prod  <= {{WIDTH{1'b0}}, b_mag};
      neg   <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (step) begin
      prod  <= {sum, prod[WIDTH-1:1]};
    end else if (fix) begin
      prod  <= result;
    end
endmodule

// File: rtl/mult_sequencer.sv
// mult_sequencer: iterative mult/multu sequencer owning the HI/LO registers.
module mult_sequencer import mips_pkg::*; #(parameter int WIDTH = 32) (
  input logic             clk,
  input logic             rst_n,
  mult_sequencer_if.slave bus
);
  mult_state_t        state, next;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   hi, lo;
  logic [2*WIDTH-1:0] result;
  logic               load, step, fix, last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= next;
  // abort wins over everything while an operation is in flight
  always_comb begin
    load = (state == IDLE || state == DONE) && bus.start && !bus.abort;
    step = state == RUN && !bus.abort;
    fix  = state == FIX && !bus.abort;
    last = count == CNT_W'(WIDTH - 1);
    next = bus.abort && (state == RUN || state == FIX) ? IDLE :
           load                                        ? RUN  :
           state == DONE                               ? IDLE :
           step && last                                ? FIX  :
           fix                                         ? DONE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)    count <= '0;
    else if (load) count <= '0;
    else if (step) count <= count + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (fix) begin
      hi <= result[2*WIDTH-1:WIDTH];
      lo <= result[WIDTH-1:0];
    end
  assign bus.busy = state == RUN || state == FIX;
  assign bus.done = state == DONE;
  assign bus.hi   = hi;
  assign bus.lo   = lo;
  mult_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk(clk), .rst_n(rst_n), .load(load), .step(step), .fix(fix),
    .signed_op(bus.signed_op), .a(bus.a), .b(bus.b), .result(result)
  );
endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer: directed vectors with a scoreboard queue checked by a done monitor.
module tb_mult_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0, errors = 0, dones = 0;
  logic [63:0] sb[$];
  logic [63:0] e;
  mult_sequencer_if #(.WIDTH(32)) bus();
  mult_sequencer #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rst_n && bus.done) begin
      dones++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got hi=%h lo=%h, required no done", bus.hi, bus.lo);
      end else begin
        e = sb.pop_front();
        chk("result", {bus.hi, bus.lo}, e);
      end
    end

  // called on a negedge; the following posedge samples start
  task automatic issue(input logic s, input logic [31:0] x, input logic [31:0] y,
                       input logic push, input logic [63:0] exp);
    if (push) sb.push_back(exp);
    bus.start = 1'b1;
    bus.signed_op = s;
    bus.a = x;
    bus.b = y;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int first, output int lat, output int bsy);
    lat = first;
    bsy = 0;
    while (!bus.done && lat < 100) begin
      if (bus.busy) bsy++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run(input logic s, input logic [31:0] x, input logic [31:0] y, input logic [63:0] exp);
    int lat, bsy;
    issue(s, x, y, 1'b1, exp);
    wait_done(1, lat, bsy);
    chk("latency", 64'(lat), 64'd34);
    chk("busy_cycles", 64'(bsy), 64'd33);
    @(negedge clk);
  endtask

  initial begin
    int lat, bsy, d0;
    bus.start = 1'b0;
    bus.signed_op = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.abort = 1'b0;
    #12;
    chk("reset_state", {30'd0, bus.busy, bus.done, bus.hi, bus.lo}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    run(1'b0, 32'd3, 32'd5, 64'h0000_0000_0000_000F);
    chk("idle_after_done", {62'd0, bus.busy, bus.done}, 64'd0);
    // abort mid-run: abort sampled at edge N+10
    issue(1'b0, 32'd7, 32'd9, 1'b0, 64'd0);
    repeat (9) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_idle", {63'd0, bus.busy}, 64'd0);
    d0 = dones;
    repeat (40) @(negedge clk);
    chk("abort_no_done", 64'(dones), 64'(d0));
    chk("abort_hilo", {bus.hi, bus.lo}, 64'h0000_0000_0000_000F);
    run(1'b1, 32'hFFFF_FFFF, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    run(1'b0, 32'hFFFF_FFFF, 32'd1, 64'h0000_0000_FFFF_FFFF);
    run(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run(1'b1, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
    // start during busy is ignored; start in DONE chains with no idle cycle
    issue(1'b0, 32'd4, 32'd5, 1'b1, 64'd20);
    repeat (4) @(negedge clk);
    issue(1'b0, 32'd2, 32'd2, 1'b0, 64'd0);
    wait_done(6, lat, bsy);
    chk("ignored_start_latency", 64'(lat), 64'd34);
    issue(1'b0, 32'd6, 32'd7, 1'b1, 64'd42);
    wait_done(1, lat, bsy);
    chk("b2b_latency", 64'(lat), 64'd34);
    chk("b2b_busy_cycles", 64'(bsy), 64'd33);
    @(negedge clk);
    // asynchronous reset between edges mid-operation
    issue(1'b0, 32'd3, 32'd5, 1'b0, 64'd0);
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("areset_outputs", {30'd0, bus.busy, bus.done, bus.hi, bus.lo}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    run(1'b0, 32'd3, 32'd5, 64'h0000_0000_0000_000F);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
